// File: rtl/reg_byte_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_byte_loader : fetches one or two bytes from memory and drives the
//                   E / FunSel / I interface of a 16-bit register.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module reg_byte_loader #(
  parameter int MEM_LAT = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Mode,
  input  logic [15:0] BaseAddr,
  input  logic [7:0]  MemData,
  output logic [15:0] MemAddr,
  output logic        MemRd,
  output logic        RegE,
  output logic [2:0]  RegFunSel,
  output logic [15:0] RegI,
  output logic        Busy,
  output logic        Done
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_RD1   = 3'd1;
  localparam logic [2:0] c_WAIT1 = 3'd2;
  localparam logic [2:0] c_WR1   = 3'd3;
  localparam logic [2:0] c_RD2   = 3'd4;
  localparam logic [2:0] c_WAIT2 = 3'd5;
  localparam logic [2:0] c_WR2   = 3'd6;
  localparam logic [2:0] c_DONE  = 3'd7;

  // WAIT lasts MEM_LAT-1 cycles: counter is loaded in RD and exits at zero
  localparam logic       c_HAS_WAIT  = (MEM_LAT > 1);
  localparam logic [1:0] c_WAIT_INIT = (MEM_LAT > 2) ? 2'(MEM_LAT - 2) : 2'd0;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [1:0]  r_mode;
  logic [15:0] r_addr;
  logic [1:0]  r_cnt;
  logic        w_byte_mode;

  assign w_byte_mode = r_mode[0] ^ r_mode[1];

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (Start) w_next = c_RD1;
      c_RD1:   w_next = c_HAS_WAIT ? c_WAIT1 : c_WR1;
      c_WAIT1: if (r_cnt == 2'd0) w_next = c_WR1;
      c_WR1:   w_next = w_byte_mode ? c_DONE : c_RD2;
      c_RD2:   w_next = c_HAS_WAIT ? c_WAIT2 : c_WR2;
      c_WAIT2: if (r_cnt == 2'd0) w_next = c_WR2;
      c_WR2:   w_next = c_DONE;
      c_DONE:  w_next = Start ? c_RD1 : c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= c_IDLE;
      r_mode  <= 2'b00;
      r_addr  <= 16'h0000;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (((r_state == c_IDLE) || (r_state == c_DONE)) && Start) begin
        r_mode <= Mode;
        r_addr <= BaseAddr;
      end
      if ((r_state == c_WR1) && (w_next == c_RD2))
        r_addr <= r_addr + 16'd1;
      if ((r_state == c_RD1) || (r_state == c_RD2))
        r_cnt <= c_WAIT_INIT;
      else if (((r_state == c_WAIT1) || (r_state == c_WAIT2)) && (r_cnt != 2'd0))
        r_cnt <= r_cnt - 2'd1;
    end
  end

  assign MemAddr = r_addr;
  assign MemRd   = (r_state == c_RD1) || (r_state == c_RD2);
  assign RegE    = (r_state == c_WR1) || (r_state == c_WR2);
  assign RegI    = RegE ? {8'h00, MemData} : 16'h0000;
  assign Busy    = (r_state != c_IDLE) && (r_state != c_DONE);
  assign Done    = (r_state == c_DONE);

  // FunSel: 100 zero-ext, 111 sign-ext, 101 load low byte, 110 load high byte
  always_comb begin
    RegFunSel = 3'b000;
    if (r_state == c_WR1) begin
      case (r_mode)
        2'b00:   RegFunSel = 3'b101;
        2'b01:   RegFunSel = 3'b100;
        2'b10:   RegFunSel = 3'b111;
        default: RegFunSel = 3'b110;
      endcase
    end else if (r_state == c_WR2) begin
      RegFunSel = (r_mode == 2'b11) ? 3'b101 : 3'b110;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_byte_loader.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for reg_byte_loader: MEM_LAT=1 instance driven from a vector table with
// a cycle-stamped scoreboard, MEM_LAT=3 instance for wrap-around and reset cases.
module tb_reg_byte_loader;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    logic [2:0]  fs;
  } ev_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] base;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp_reg;
    int          lat;
    bit          b2b;
    int          restart;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset, Start1, Start3;
  logic [1:0]  Mode;
  logic [15:0] BaseAddr;
  logic [7:0]  MemData1, MemData3;
  logic [15:0] MemAddr1, MemAddr3, RegI1, RegI3;
  logic        MemRd1, MemRd3, RegE1, RegE3, Busy1, Busy3, Done1, Done3;
  logic [2:0]  RegFunSel1, RegFunSel3;

  reg_byte_loader #(.MEM_LAT(1)) dut1 (
    .Clock(clk), .Reset(Reset), .Start(Start1), .Mode(Mode), .BaseAddr(BaseAddr),
    .MemData(MemData1), .MemAddr(MemAddr1), .MemRd(MemRd1), .RegE(RegE1),
    .RegFunSel(RegFunSel1), .RegI(RegI1), .Busy(Busy1), .Done(Done1));

  reg_byte_loader #(.MEM_LAT(3)) dut3 (
    .Clock(clk), .Reset(Reset), .Start(Start3), .Mode(Mode), .BaseAddr(BaseAddr),
    .MemData(MemData3), .MemAddr(MemAddr3), .MemRd(MemRd3), .RegE(RegE3),
    .RegFunSel(RegFunSel3), .RegI(RegI3), .Busy(Busy3), .Done(Done3));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // byte memory with MEM_LAT-deep read pipes; filler byte exposes early sampling
  logic [7:0] mem [0:65535];
  logic [7:0] p1;
  logic [7:0] p3 [0:2];
  always @(posedge clk) begin
    p1    <= MemRd1 ? mem[MemAddr1] : 8'hEE;
    p3[0] <= MemRd3 ? mem[MemAddr3] : 8'hEE;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign MemData1 = p1;
  assign MemData3 = p3[2];

  int checks = 0;
  int failures = 0;
  ev_t rdq[$];
  ev_t wrq[$];
  logic [15:0] rd3q[$];
  logic [15:0] reg1 = 16'h0000;
  logic [15:0] reg3 = 16'h0000;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] apply_fs(input logic [15:0] r, input logic [2:0] fs,
                                           input logic [15:0] i);
    case (fs)
      3'b100:  return {8'h00, i[7:0]};
      3'b111:  return {{8{i[7]}}, i[7:0]};
      3'b101:  return {r[15:8], i[7:0]};
      3'b110:  return {i[7:0], r[7:0]};
      default: return r;
    endcase
  endfunction

  function automatic logic [2:0] fs_first(input logic [1:0] m);
    case (m)
      2'b00:   return 3'b101;
      2'b01:   return 3'b100;
      2'b10:   return 3'b111;
      default: return 3'b110;
    endcase
  endfunction

  function automatic logic [2:0] fs_second(input logic [1:0] m);
    return (m == 2'b11) ? 3'b101 : 3'b110;
  endfunction

  // scoreboard consumer for the MEM_LAT=1 instance
  initial begin
    ev_t  e;
    logic done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (MemRd1) begin
        chk("rd1_expected", 32'(rdq.size() != 0), 1);
        if (rdq.size() != 0) begin
          e = rdq.pop_front();
          chk("rd1_cycle", cyc, e.cyc);
          chk("rd1_addr", MemAddr1, e.val);
        end
      end
      if (RegE1) begin
        chk("wr1_expected", 32'(wrq.size() != 0), 1);
        if (wrq.size() != 0) begin
          e = wrq.pop_front();
          chk("wr1_cycle", cyc, e.cyc);
          chk("wr1_funsel", RegFunSel1, e.fs);
          chk("wr1_regi", RegI1, e.val);
        end
        reg1 = apply_fs(reg1, RegFunSel1, RegI1);
      end else begin
        chk("funsel_idle", RegFunSel1, 0);
      end
      if (Done1) chk("done_single_cycle", done_prev, 0);
      done_prev = Done1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (MemRd3) rd3q.push_back(MemAddr3);
      if (RegE3) reg3 = apply_fs(reg3, RegFunSel3, RegI3);
    end
  end

  task automatic launch1(input vec_t v, output int t0);
    logic [15:0] a2;
    logic        word;
    a2   = v.base + 16'd1;
    word = (v.mode == 2'b00) || (v.mode == 2'b11);
    mem[v.base] = v.b0;
    mem[a2]     = v.b1;
    Start1 = 1'b1; Mode = v.mode; BaseAddr = v.base;
    t0 = cyc;
    rdq.push_back('{t0 + 1, v.base, 3'b000});
    wrq.push_back('{t0 + 2, {8'h00, v.b0}, fs_first(v.mode)});
    if (word) begin
      rdq.push_back('{t0 + 3, a2, 3'b000});
      wrq.push_back('{t0 + 4, {8'h00, v.b1}, fs_second(v.mode)});
    end
    @(posedge clk); #1;
    Start1 = 1'b0; Mode = ~v.mode; BaseAddr = 16'($urandom());
  endtask

  task automatic await1(input int t0, input vec_t v);
    int dc = 0;
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (v.restart != 0 && cyc == t0 + v.restart) begin
        Start1 = 1'b1; BaseAddr = 16'h0200; Mode = 2'b01;
      end else if (v.restart != 0 && cyc == t0 + v.restart + 1) begin
        Start1 = 1'b0;
      end
      if (Done1) begin
        found = 1'b1; dc = cyc;
        chk("busy_at_done", Busy1, 0);
      end else begin
        chk("busy_in_txn", Busy1, 1);
      end
    end
    chk("done1_seen", found, 1);
    if (found) chk("latency1", dc - t0, v.lat);
    chk("reg1_value", reg1, v.exp_reg);
  endtask

  task automatic run3(input logic [1:0] m, input logic [15:0] base, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [15:0] exp_reg, input int exp_lat);
    logic [15:0] a2;
    bit word, found;
    int t0, dc;
    a2 = base + 16'd1;
    word = (m == 2'b00) || (m == 2'b11);
    mem[base] = b0; mem[a2] = b1;
    rd3q.delete();
    @(posedge clk); #1;
    Start3 = 1'b1; Mode = m; BaseAddr = base; t0 = cyc;
    @(posedge clk); #1;
    Start3 = 1'b0; Mode = ~m;
    found = 1'b0; dc = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (Done3) begin found = 1'b1; dc = cyc; end
    end
    chk("done3_seen", found, 1);
    if (found) chk("latency3", dc - t0, exp_lat);
    chk("rd3_count", rd3q.size(), word ? 2 : 1);
    if (rd3q.size() >= 1) chk("rd3_addr_first", rd3q[0], base);
    if (word && rd3q.size() >= 2) chk("rd3_addr_second", rd3q[1], a2);
    chk("reg3_value", reg3, exp_reg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    vecs[0] = '{2'b00, 16'h0040, 8'h34, 8'h12, 16'h1234, 5, 1'b0, 0};
    vecs[1] = '{2'b11, 16'h0040, 8'h34, 8'h12, 16'h3412, 5, 1'b0, 0};
    vecs[2] = '{2'b10, 16'h0010, 8'h85, 8'h00, 16'hFF85, 3, 1'b0, 0};
    vecs[3] = '{2'b01, 16'h0010, 8'h85, 8'h00, 16'h0085, 3, 1'b0, 0};
    vecs[4] = '{2'b00, 16'h0100, 8'h5A, 8'hC3, 16'hC35A, 5, 1'b0, 2};
    vecs[5] = '{2'b10, 16'h0020, 8'h7F, 8'h00, 16'h007F, 3, 1'b1, 0};
    vecs[6] = '{2'b11, 16'h8000, 8'h01, 8'h80, 16'h0180, 5, 1'b1, 0};
    vecs[7] = '{2'b01, 16'hFFFF, 8'hF0, 8'h00, 16'h00F0, 3, 1'b0, 0};

    // reset with Start held high: everything must stay quiet
    Reset = 1'b1; Start1 = 1'b1; Start3 = 1'b1; Mode = 2'b00; BaseAddr = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst1_addr", MemAddr1, 0);
    chk("rst1_ctl", {MemRd1, RegE1, RegFunSel1, Busy1, Done1}, 0);
    chk("rst1_regi", RegI1, 0);
    chk("rst3_ctl", {MemRd3, RegE3, RegFunSel3, Busy3, Done3}, 0);
    @(posedge clk); #1;
    Reset = 1'b0; Start1 = 1'b0; Start3 = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {Busy1, MemRd1, Busy3, MemRd3}, 0);

    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].b2b) begin
        @(posedge clk); #1;
      end
      launch1(vecs[i], t0);
      await1(t0, vecs[i]);
    end

    run3(2'b00, 16'hFFFF, 8'h11, 8'h22, 16'h2211, 9);
    run3(2'b10, 16'h0050, 8'h90, 8'h00, 16'hFF90, 5);

    // reset in each state of a MEM_LAT=3 word load (k=0 is the Start cycle itself)
    for (int k = 0; k <= 9; k++) begin
      logic any;
      @(posedge clk); #1;
      Start3 = 1'b1; Mode = 2'b00; BaseAddr = 16'h0300; t0 = cyc;
      if (k == 0) Reset = 1'b1;
      @(posedge clk); #1;
      Start3 = 1'b0; Reset = 1'b0;
      for (int j = 1; j <= k; j++) begin
        if (j == k) begin Reset = 1'b1; Start3 = 1'b1; end
        @(posedge clk); #1;
        Reset = 1'b0; Start3 = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("rst_k%0d_addr", k), MemAddr3, 0);
      chk($sformatf("rst_k%0d_ctl", k), {MemRd3, RegE3, RegFunSel3, Busy3, Done3}, 0);
      chk($sformatf("rst_k%0d_regi", k), RegI3, 0);
      any = 1'b0;
      repeat (6) begin
        @(negedge clk);
        any = any | MemRd3 | RegE3 | Done3 | Busy3;
      end
      chk($sformatf("rst_k%0d_quiet", k), any, 0);
    end

    chk("rdq_drained", rdq.size(), 0);
    chk("wrq_drained", wrq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
